// File: rtl/product_bcd_converter_if.sv
// Handshake and data bundle between the multiplier top level and the BCD converter.
//   start : one-cycle conversion request (master -> slave)
//   bin   : unsigned binary value to convert (master -> slave)
//   busy  : conversion in progress (slave -> master)
//   done  : one-cycle pulse, bcd just updated (slave -> master)
//   bcd   : packed BCD result, ones digit in [3:0] (slave -> master)
interface product_bcd_converter_if #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = 5
);
  logic                  start;
  logic [WIDTH-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;

  modport master (output start, bin, input busy, done, bcd);
  modport slave  (input start, bin, output busy, done, bcd);
endinterface

// File: rtl/product_bcd_converter.sv
// Iterative double-dabble binary-to-BCD converter for the multiplier display path.
//   CLOCK_50 : system clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : slave side of product_bcd_converter_if (start/bin in, busy/done/bcd out)
// One WIDTH-bit value is converted in WIDTH cycles; the last result is held on bcd.
module product_bcd_converter #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic                     CLOCK_50,
  input  logic                     reset_n,
  product_bcd_converter_if.slave   bus
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned REG_W = BCD_W + WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH);

  typedef enum logic {IDLE, CONVERT} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [REG_W-1:0]   work_q, work_d;
  logic [REG_W-1:0]   adj;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // State and output registers
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      bcd_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      bcd_q   <= bcd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic and one add-3/shift iteration per CONVERT cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    bcd_d   = bcd_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    adj     = work_q;

    // Each digit is <= 9 before the add, so the +3 never carries out of its nibble
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (work_q[WIDTH + 4*i +: 4] >= 4'd5) begin
        adj[WIDTH + 4*i +: 4] = work_q[WIDTH + 4*i +: 4] + 4'd3;
      end
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          work_d  = {BCD_W'(0), bus.bin};
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        work_d = adj << 1;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          bcd_d   = work_d[REG_W-1 -: BCD_W];
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.bcd  = bcd_q;

endmodule
